arbiter_wrr: RTL and testbench

//  Weighted round-robin arbiter, successor to the plain round-robin arbiter.

---
 rtl/arbiter_wrr.sv | 159 +++++++++++++++
 tb/tb_arbiter_wrr.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_wrr.sv
// arbiter_wrr: weighted round-robin arbiter; each grant carries a beat credit of max(weight,1).
// Define ARB_WRR_TIMEOUT_EN to add an ack-silence watchdog that revokes a stalled grant.
module arbiter_wrr #(
  parameter int PORTS             = 4,
  parameter int WW                = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS-1:0]           request,
  input  logic [PORTS-1:0]           acknowledge,
  input  logic [PORTS*WW-1:0]        weight,
  output logic [PORTS-1:0]           grant,
  output logic                       grant_valid,
  output logic [$clog2(PORTS)-1:0]   grant_encoded,
  output logic [WW-1:0]              credit_left,
  output logic                       timeout_err
);

  localparam int IW = $clog2(PORTS);
  localparam logic [IW-1:0] LAST_RST = LSB_HIGH_PRIORITY ? IW'(PORTS - 1) : '0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [PORTS-1:0]  grant_reg, grant_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [IW-1:0]     last_idx_reg, last_idx_next;
  logic [WW-1:0]     credit_reg, credit_next;

  logic [WW-1:0]     weight_eff [PORTS];
  logic              winner_found;
  logic [IW-1:0]     winner_idx;
  logic [IW-1:0]     cand_idx;
  logic              beat;
  logic              release_now;
  logic              watchdog_fire;

  // A zero weight still buys one beat, so every grant makes progress.
  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_weight
      assign weight_eff[gi] = (weight[gi*WW +: WW] == '0) ? WW'(1) : weight[gi*WW +: WW];
    end
  endgenerate

  // Circular search beginning just past last_idx; last_idx itself is visited last.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    cand_idx     = '0;
    for (int k = 1; k <= PORTS; k++) begin
      if (LSB_HIGH_PRIORITY)
        cand_idx = IW'((int'(last_idx_reg) + k) % PORTS);
      else
        cand_idx = IW'((int'(last_idx_reg) + PORTS - k) % PORTS);
      if (!winner_found && request[cand_idx]) begin
        winner_found = 1'b1;
        winner_idx   = cand_idx;
      end
    end
  end

  assign beat = (state_reg == GRANT) && acknowledge[idx_reg];

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    idx_next      = idx_reg;
    credit_next   = credit_reg;
    last_idx_next = last_idx_reg;
    release_now   = 1'b0;

    if (state_reg == GRANT) begin
      if (beat) begin
        if (credit_reg != '0)
          credit_next = credit_reg - WW'(1);
        if (credit_reg <= WW'(1))
          release_now = 1'b1;
      end else if (!request[idx_reg] || watchdog_fire) begin
        release_now = 1'b1;
      end
    end

    // Release and the next grant share one edge, so there is no idle bubble.
    if ((state_reg == IDLE) || release_now) begin
      if (winner_found) begin
        state_next    = GRANT;
        grant_next    = PORTS'(1) << winner_idx;
        idx_next      = winner_idx;
        credit_next   = weight_eff[winner_idx];
        last_idx_next = winner_idx;
      end else begin
        state_next  = IDLE;
        grant_next  = '0;
        idx_next    = '0;
        credit_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      idx_reg      <= '0;
      credit_reg   <= '0;
      last_idx_reg <= LAST_RST;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      idx_reg      <= idx_next;
      credit_reg   <= credit_next;
      last_idx_reg <= last_idx_next;
    end
  end

`ifdef ARB_WRR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_reg, timer_next;
  logic          timeout_err_reg;

  // Fires in the silent cycle that completes TIMEOUT_CYCLES beat-less cycles.
  assign watchdog_fire = (state_reg == GRANT) && !beat &&
                         (timer_reg == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    timer_next = '0;
    if ((state_reg == GRANT) && !beat && !release_now)
      timer_next = timer_reg + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timer_reg       <= timer_next;
      timeout_err_reg <= watchdog_fire;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign watchdog_fire = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  assign grant         = grant_reg;
  assign grant_valid   = (state_reg == GRANT);
  assign grant_encoded = idx_reg;
  assign credit_left   = credit_reg;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Self-checking bench for arbiter_wrr: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_arbiter_wrr;

  localparam int PORTS = 4;
  localparam int WW    = 4;
  localparam int TC    = 16;
  localparam bit LSB   = 1'b1;
`ifdef ARB_WRR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [PORTS-1:0]     request = '0;
  logic [PORTS-1:0]     acknowledge = '0;
  logic [PORTS*WW-1:0]  weight = '0;
  logic [PORTS-1:0]     grant;
  logic                 grant_valid;
  logic [1:0]           grant_encoded;
  logic [WW-1:0]        credit_left;
  logic                 timeout_err;

  always #5 clk = ~clk;

  arbiter_wrr #(
    .PORTS(PORTS), .WW(WW), .LSB_HIGH_PRIORITY(LSB), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
    .weight(weight), .grant(grant), .grant_valid(grant_valid),
    .grant_encoded(grant_encoded), .credit_left(credit_left), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  wire [11:0] obs = {grant_valid, grant, grant_encoded, credit_left, timeout_err};

  // Behavioural model: who holds the bus, how many beats remain, silence count.
  bit m_busy;
  int m_port, m_credit, m_last, m_timer, m_w;
  bit m_tout, m_rel;

  int seq_p [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
  int seq_c [10] = '{1, 2, 1, 3, 2, 1, 4, 3, 2, 1};

  function automatic int pick(int from);
    for (int k = 1; k <= PORTS; k++) begin
      int c;
      c = LSB ? (from + k) % PORTS : (from + PORTS - k) % PORTS;
      if (request[c]) return c;
    end
    return -1;
  endfunction

  function automatic int wt(int p);
    int w;
    w = int'(weight[p*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic [11:0] m_exp();
    logic [3:0] g;
    logic [1:0] e;
    logic [3:0] c;
    g = m_busy ? 4'(1 << m_port) : 4'b0;
    e = m_busy ? 2'(m_port) : 2'b0;
    c = m_busy ? 4'(m_credit) : 4'b0;
    return {m_busy, g, e, c, m_tout};
  endfunction

  task automatic m_grant_to(int p);
    m_busy   = 1'b1;
    m_port   = p;
    m_credit = wt(p);
    m_last   = p;
    m_timer  = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_port = 0; m_credit = 0; m_timer = 0; m_tout = 1'b0;
      m_last = LSB ? PORTS - 1 : 0;
    end else begin
      m_tout = 1'b0;
      m_rel  = 1'b0;
      if (!m_busy) begin
        m_w = pick(m_last);
        if (m_w >= 0) m_grant_to(m_w);
      end else begin
        if (acknowledge[m_port]) begin
          m_credit = m_credit - 1;
          m_timer  = 0;
          m_rel    = (m_credit == 0);
        end else begin
          m_timer = m_timer + 1;
          if (!request[m_port]) m_rel = 1'b1;
          if (TO_EN && m_timer >= TC) begin
            m_rel  = 1'b1;
            m_tout = 1'b1;
          end
        end
        if (m_rel) begin
          m_w = pick(m_port);
          if (m_w >= 0) m_grant_to(m_w);
          else begin
            m_busy = 1'b0; m_credit = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; request = '0; acknowledge = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; request = '0; acknowledge = '0; weight = '0;
    @(negedge clk);
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++; $display("FAIL reset_state: got %h want 000", obs);
    end
    rst_n = 1'b1; request = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 || credit_left !== 4'd1) begin
      n_bad++; $display("FAIL reset_first_grant: got g=%b v=%b c=%0d want g=0001 v=1 c=1", grant, grant_valid, credit_left);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++; $display("FAIL reset_async_mid_grant: got %h want 000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 || credit_left !== 4'd1) begin
      n_bad++; $display("FAIL reset_regrant: got g=%b v=%b c=%0d want g=0001 v=1 c=1", grant, grant_valid, credit_left);
    end
  endtask

  task automatic test_wrr();
    do_reset();
    weight = {4'd4, 4'd3, 4'd2, 4'd1}; request = 4'hF; acknowledge = 4'hF;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (grant !== 4'(1 << seq_p[k % 10]) || credit_left !== 4'(seq_c[k % 10]) || grant_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL wrr_seq[%0d]: got g=%b c=%0d v=%b want g=%b c=%0d v=1", k, grant, credit_left,
                 grant_valid, 4'(1 << seq_p[k % 10]), seq_c[k % 10]);
      end
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++; $display("FAIL wrr_model[%0d]: got %h want %h", k, obs, m_exp());
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    weight = {4'd4, 4'd3, 4'd2, 4'd1}; request = 4'b0100; acknowledge = '0;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0100 || credit_left !== 4'd3) begin
      n_bad++; $display("FAIL early_grant2: got g=%b c=%0d want g=0100 c=3", grant, credit_left);
    end
    request = 4'b1100; acknowledge = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0100 || credit_left !== 4'd2) begin
      n_bad++; $display("FAIL early_beat: got g=%b c=%0d want g=0100 c=2", grant, credit_left);
    end
    request = 4'b1000; acknowledge = '0;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b1000 || grant_encoded !== 2'd3 || credit_left !== 4'd4) begin
      n_bad++; $display("FAIL early_release: got g=%b e=%0d c=%0d want g=1000 e=3 c=4", grant, grant_encoded, credit_left);
    end
  endtask

  task automatic test_sole();
    do_reset();
    weight = {4'd1, 4'd1, 4'd2, 4'd1}; request = 4'b0010; acknowledge = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (grant_valid !== 1'b1 || grant !== 4'b0010 || credit_left !== ((k % 2 == 0) ? 4'd2 : 4'd1)) begin
        n_bad++; $display("FAIL sole[%0d]: got v=%b g=%b c=%0d want v=1 g=0010 c=%0d", k, grant_valid, grant,
                          credit_left, (k % 2 == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic test_weight();
    do_reset();
    weight = '0; request = 4'b0001; acknowledge = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (grant !== 4'b0001 || credit_left !== 4'd1) begin
        n_bad++; $display("FAIL weight0[%0d]: got g=%b c=%0d want g=0001 c=1", k, grant, credit_left);
      end
    end
    weight = 16'h0050; request = 4'b0010; acknowledge = '0;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0010 || credit_left !== 4'd5) begin
      n_bad++; $display("FAIL weight_load: got g=%b c=%0d want g=0010 c=5", grant, credit_left);
    end
    weight = 16'h0020; acknowledge = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0010 || credit_left !== 4'd4) begin
      n_bad++; $display("FAIL weight_midchange: got g=%b c=%0d want g=0010 c=4", grant, credit_left);
    end
    acknowledge = '0;
    @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0010 || credit_left !== 4'd4) begin
      n_bad++; $display("FAIL weight_hold: got g=%b c=%0d want g=0010 c=4", grant, credit_left);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] want_g;
    do_reset();
    weight = 16'h1111; request = 4'b0011; acknowledge = '0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      want_g = (TO_EN && k >= 16) ? 4'b0010 : 4'b0001;
      n_cmp++;
      if (grant !== want_g || timeout_err !== (TO_EN && k == 16)) begin
        n_bad++; $display("FAIL timeout[%0d]: got g=%b t=%b want g=%b t=%b", k, grant, timeout_err,
                          want_g, (TO_EN && k == 16));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    weight = 16'h2311;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== m_exp()) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", k, obs, m_exp());
      end
      request     = 4'($urandom);
      acknowledge = 4'($urandom) | ((($urandom_range(0, 3)) == 0) ? 4'h0 : 4'($urandom));
      if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_wrr();
    test_early_release();
    test_sole();
    test_weight();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
